// File: rtl/wptr_full_level_pkg.sv
// Shared FIFO definitions: default address width, almost-full margin and the
// binary-to-gray helper used by both pointer domains.
package wptr_full_level_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int AF_MARGIN_DEF  = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

endpackage

// File: rtl/wptr_full_level_gray2bin.sv
// Gray-to-binary converter: XOR prefix chain running down from the MSB.
// Shared with the read-side level logic.
module gray2bin #(
    parameter int n = 4
) (
    input  logic [n-1:0] gray,
    output logic [n-1:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above it
    always_comb begin
        logic acc_s;
        acc_s = 1'b0;
        bin   = '0;
        for (int i = n - 1; i >= 0; i--) begin
            acc_s  = acc_s ^ gray[i];
            bin[i] = acc_s;
        end
    end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side gray pointer, registered full/almost-full, fill level and sticky
// overflow. Optional dropped-write counter enabled by WPTR_FULL_OVF_COUNT_EN.
module wptr_full_level
    import wptr_full_level_pkg::*;
#(
    parameter int addr_width         = ADDR_WIDTH_DEF,
    parameter int almost_full_thresh = 2**addr_width - AF_MARGIN_DEF
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [addr_width:0]   wq2_rptr,
    input  logic                  wovf_clr,
    output logic [addr_width-1:0] waddr,
    output logic [addr_width:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [addr_width:0]   wlevel,
    output logic                  woverflow,
    output logic [7:0]            wovf_count
);

    localparam int                  ptr_w_c  = addr_width + 1;
    localparam logic [addr_width:0] thresh_c = ptr_w_c'(almost_full_thresh);

    logic [addr_width:0] wbin_r;
    logic [addr_width:0] wptr_r;
    logic                wfull_r;
    logic                walmost_full_r;
    logic [addr_width:0] wlevel_r;
    logic                woverflow_r;

    logic [addr_width:0] wbinnext_s;
    logic [addr_width:0] wgraynext_s;
    logic [addr_width:0] rbin_s;
    logic [addr_width:0] level_next_s;
    logic                wfull_val_s;
    logic                ovf_ev_s;
    logic                woverflow_next_s;

    gray2bin #(.n(ptr_w_c)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Next pointer, full compare, level and overflow next-state
    always_comb begin
        ovf_ev_s     = winc & wfull_r;
        wbinnext_s   = wbin_r + {{addr_width{1'b0}}, (winc & ~wfull_r)};
        wgraynext_s  = ptr_w_c'(bin2gray(32'(wbinnext_s)));
        // Full when the write pointer is exactly one lap ahead of the read pointer
        wfull_val_s  = (wgraynext_s == {~wq2_rptr[addr_width:addr_width-1],
                                         wq2_rptr[addr_width-2:0]});
        level_next_s = wbinnext_s - rbin_s;
        if (ovf_ev_s) begin
            woverflow_next_s = 1'b1;
        end else if (wovf_clr) begin
            woverflow_next_s = 1'b0;
        end else begin
            woverflow_next_s = woverflow_r;
        end
    end

    // Pointer, flag and level registers
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_r         <= '0;
            wptr_r         <= '0;
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wlevel_r       <= '0;
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbinnext_s;
            wptr_r         <= wgraynext_s;
            wfull_r        <= wfull_val_s;
            walmost_full_r <= (level_next_s >= thresh_c);
            wlevel_r       <= level_next_s;
            woverflow_r    <= woverflow_next_s;
        end
    end

`ifdef WPTR_FULL_OVF_COUNT_EN
    logic [7:0] wovf_count_r;
    logic [7:0] wovf_count_next_s;

    // Saturating dropped-write counter; a drop in the clear cycle counts as one
    always_comb begin
        if (ovf_ev_s) begin
            if (wovf_clr) begin
                wovf_count_next_s = 8'd1;
            end else if (wovf_count_r == 8'hFF) begin
                wovf_count_next_s = wovf_count_r;
            end else begin
                wovf_count_next_s = wovf_count_r + 8'd1;
            end
        end else if (wovf_clr) begin
            wovf_count_next_s = 8'd0;
        end else begin
            wovf_count_next_s = wovf_count_r;
        end
    end

    // Dropped-write counter register
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf_count_r <= 8'd0;
        end else begin
            wovf_count_r <= wovf_count_next_s;
        end
    end

    assign wovf_count = wovf_count_r;
`else
    assign wovf_count = 8'd0;
`endif

    assign waddr        = wbin_r[addr_width-1:0];
    assign wptr         = wptr_r;
    assign wfull        = wfull_r;
    assign walmost_full = walmost_full_r;
    assign wlevel       = wlevel_r;
    assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed, table-driven bench for wptr_full_level at addr_width=4, threshold 12.
module tb_wptr_full_level;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;
    logic [7:0] wovf_count;

    int n_cmp;
    int n_bad;

    wptr_full_level #(
        .addr_width         (4),
        .almost_full_thresh (12)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow),
        .wovf_count   (wovf_count)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        string      name;
        logic       winc;
        logic [4:0] rptr;
        logic       clr;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [7:0] ecnt(input int c);
`ifdef WPTR_FULL_OVF_COUNT_EN
        return 8'(c);
`else
        return (c == 0) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic add(input string nm, input logic wi, input logic [4:0] rp, input logic cl,
                       input logic [3:0] wa, input logic [4:0] wp, input logic fu,
                       input logic af, input logic [4:0] lv, input logic ov, input logic [7:0] cn);
        vec_t v;
        v.name = nm; v.winc = wi; v.rptr = rp; v.clr = cl; v.waddr = wa; v.wptr = wp;
        v.full = fu; v.af = af; v.level = lv; v.ovf = ov; v.cnt = cn;
        tbl.push_back(v);
    endtask

    logic [4:0] prev_ptr;
    int         b;

    initial begin
        n_cmp = 0; n_bad = 0;
        wrst = 1'b1; winc = 1'b0; wq2_rptr = 5'd0; wovf_clr = 1'b0;

        // Scenario 1: 16 writes, read pointer held at 0
        for (int k = 1; k <= 16; k++)
            add($sformatf("fill%0d", k), 1'b1, 5'd0, 1'b0, 4'(k), g(k),
                (k == 16), (k >= 12), 5'(k), 1'b0, 8'd0);
        // Scenario 2: writes while full are dropped
        add("ovf1", 1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, ecnt(1));
        add("ovf2", 1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, ecnt(2));
        add("ovf3", 1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, ecnt(3));
        add("ovf_set_wins", 1'b1, 5'd0, 1'b1, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, ecnt(1));
        add("ovf_clr", 1'b0, 5'd0, 1'b1, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0, ecnt(0));
        // Scenario 3: read pointer jumps to 4
        add("rd_adv", 1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b0, ecnt(0));
        add("wr17", 1'b1, 5'b00110, 1'b0, 4'd1, 5'b11001, 1'b0, 1'b1, 5'd13, 1'b0, ecnt(0));
        add("wr18", 1'b1, 5'b00110, 1'b0, 4'd2, 5'b11011, 1'b0, 1'b1, 5'd14, 1'b0, ecnt(0));
        add("wr19", 1'b1, 5'b00110, 1'b0, 4'd3, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0, ecnt(0));
        // Scenario 6: write and read advance together at level 15
        add("wr_rd_same", 1'b1, 5'b00111, 1'b0, 4'd4, 5'b11110, 1'b0, 1'b1, 5'd15, 1'b0, ecnt(0));
        add("refill", 1'b1, 5'b00111, 1'b0, 4'd5, 5'b11111, 1'b1, 1'b1, 5'd16, 1'b0, ecnt(0));

        repeat (2) @(negedge wclk);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wptr", 32'(wptr), 32'd0);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_af", 32'(walmost_full), 32'd0);
        chk("rst_level", 32'(wlevel), 32'd0);
        chk("rst_ovf", 32'(woverflow), 32'd0);
        chk("rst_cnt", 32'(wovf_count), 32'd0);
        wrst = 1'b0;

        foreach (tbl[i]) begin
            winc = tbl[i].winc; wq2_rptr = tbl[i].rptr; wovf_clr = tbl[i].clr;
            step();
            chk({tbl[i].name, "_waddr"}, 32'(waddr), 32'(tbl[i].waddr));
            chk({tbl[i].name, "_wptr"}, 32'(wptr), 32'(tbl[i].wptr));
            chk({tbl[i].name, "_wfull"}, 32'(wfull), 32'(tbl[i].full));
            chk({tbl[i].name, "_af"}, 32'(walmost_full), 32'(tbl[i].af));
            chk({tbl[i].name, "_level"}, 32'(wlevel), 32'(tbl[i].level));
            chk({tbl[i].name, "_ovf"}, 32'(woverflow), 32'(tbl[i].ovf));
            chk({tbl[i].name, "_cnt"}, 32'(wovf_count), 32'(tbl[i].cnt));
        end
        winc = 1'b0; wovf_clr = 1'b0;

        // Scenario 5: asynchronous reset mid-burst at level 9
        wrst = 1'b1; step(); wrst = 1'b0; wq2_rptr = 5'd0;
        winc = 1'b1;
        repeat (9) step();
        chk("pre_rst_level", 32'(wlevel), 32'd9);
        #2 wrst = 1'b1;
        #1;
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wptr", 32'(wptr), 32'd0);
        chk("arst_level", 32'(wlevel), 32'd0);
        chk("arst_af", 32'(walmost_full), 32'd0);
        chk("arst_full", 32'(wfull), 32'd0);
        winc = 1'b0;
        @(negedge wclk);
        wrst = 1'b0;
        step();
        chk("resume_waddr0", 32'(waddr), 32'd0);
        winc = 1'b1;
        step();
        chk("resume_waddr1", 32'(waddr), 32'd1);
        chk("resume_wptr", 32'(wptr), 32'd1);
        chk("resume_level", 32'(wlevel), 32'd1);
        step();
        chk("track_start_level", 32'(wlevel), 32'd2);

        // Scenario 4: 40 writes, read pointer 2 behind, wrapping past 31
        b = 2;
        for (int k = 0; k < 40; k++) begin
            prev_ptr = wptr;
            winc = 1'b1;
            wq2_rptr = g(b + 1 - 2);
            step();
            b = (b + 1) % 32;
            chk("track_wptr", 32'(wptr), 32'(g(b)));
            chk("track_1bit", 32'($countones(wptr ^ prev_ptr)), 32'd1);
            chk("track_level", 32'(wlevel), 32'd2);
            chk("track_full", 32'(wfull), 32'd0);
        end
        winc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
